// File: rtl/spi_flash_responder.sv
// spi_flash_responder: SPI mode-0 slave that answers serial-NOR style READ
// transactions from a byte-wide backing store. SCK, CS_N and MOSI are
// oversampled in the clk domain, so nothing here runs on the SPI clock.
// Optional build macro FAST_READ_EN adds opcode 0x0B with 8 dummy clocks.
module spi_flash_responder #(
    parameter int         ADDR_WIDTH = 24,
    parameter logic [7:0] READ_CMD   = 8'h03
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  spi_clk,
    input  logic                  spi_cs_n,
    input  logic                  spi_mosi,
    output logic                  spi_miso,
    output logic                  spi_miso_oe,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_rstrb,
    input  logic [7:0]            mem_rdata,
    output logic                  active,
    output logic                  bad_cmd
);

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        ADDR,
        DUMMY,
        DATA,
        IGNORE
    } state_t;

    state_t state;
    state_t next_state;

    logic [1:0]  sck_sync;
    logic [1:0]  cs_sync;
    logic [1:0]  mosi_sync;
    logic        sck_prev;
    logic        cs_prev;

    logic        sck_s;
    logic        cs_s;
    logic        mosi_s;
    logic        sck_rise;
    logic        sck_fall;
    logic        cs_fall;

    logic [4:0]  bit_cnt;
    logic [7:0]  cmd_sr;
    logic [23:0] addr_sr;
    logic [7:0]  shifter;
    logic [7:0]  prefetch;
    logic        rstrb_q;
    logic        fast_q;

    logic [7:0]  opcode_next;
    logic [23:0] addr_next;
    logic        is_read;
    logic        is_fast;
    logic        opcode_ok;

    assign sck_s    = sck_sync[1];
    assign cs_s     = cs_sync[1];
    assign mosi_s   = mosi_sync[1];
    assign sck_rise = sck_s & ~sck_prev;
    assign sck_fall = ~sck_s & sck_prev;
    assign cs_fall  = cs_prev & ~cs_s;

    assign opcode_next = {cmd_sr[6:0], mosi_s};
    assign addr_next   = {addr_sr[22:0], mosi_s};
    assign is_read     = (opcode_next == READ_CMD);
`ifdef FAST_READ_EN
    assign is_fast     = (opcode_next == 8'h0B);
`else
    assign is_fast     = 1'b0;
`endif
    assign opcode_ok   = is_read | is_fast;

    // Two-flop synchronisers plus previous-value registers for edge detection.
    // CS resets to "low" so a CS held low across reset is not taken as a new
    // assertion; the master must raise and lower it again.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sck_sync  <= 2'b00;
            cs_sync   <= 2'b00;
            mosi_sync <= 2'b00;
            sck_prev  <= 1'b0;
            cs_prev   <= 1'b0;
        end else begin
            sck_sync  <= {sck_sync[0], spi_clk};
            cs_sync   <= {cs_sync[0], spi_cs_n};
            mosi_sync <= {mosi_sync[0], spi_mosi};
            sck_prev  <= sck_s;
            cs_prev   <= cs_s;
        end
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state decode; a deasserted CS overrides every other transition.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (cs_fall) next_state = CMD;
            CMD:     if (sck_rise && bit_cnt == 5'd7)
                         next_state = opcode_ok ? ADDR : IGNORE;
            ADDR:    if (sck_rise && bit_cnt == 5'd23)
                         next_state = fast_q ? DUMMY : DATA;
            DUMMY:   if (sck_rise && bit_cnt == 5'd7) next_state = DATA;
            DATA:    next_state = DATA;
            IGNORE:  next_state = IGNORE;
            default: next_state = IDLE;
        endcase
        if (cs_s) next_state = IDLE;
    end

    // Shift registers, bit counting, MISO drive and the prefetch pipeline.
    // A strobe raised here is seen by the store next cycle and its data is
    // captured into prefetch one cycle after that.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bit_cnt     <= 5'd0;
            cmd_sr      <= 8'h00;
            addr_sr     <= 24'h000000;
            shifter     <= 8'h00;
            prefetch    <= 8'h00;
            rstrb_q     <= 1'b0;
            fast_q      <= 1'b0;
            mem_addr    <= '0;
            mem_rstrb   <= 1'b0;
            spi_miso    <= 1'b0;
            spi_miso_oe <= 1'b0;
            active      <= 1'b0;
            bad_cmd     <= 1'b0;
        end else begin
            mem_rstrb <= 1'b0;
            bad_cmd   <= 1'b0;
            rstrb_q   <= mem_rstrb;
            if (cs_s) begin
                bit_cnt     <= 5'd0;
                spi_miso    <= 1'b0;
                spi_miso_oe <= 1'b0;
                active      <= 1'b0;
                rstrb_q     <= 1'b0;
                fast_q      <= 1'b0;
                prefetch    <= 8'h00;
            end else begin
                if (rstrb_q) prefetch <= mem_rdata;
                case (state)
                    IDLE: begin
                        if (cs_fall) begin
                            active  <= 1'b1;
                            bit_cnt <= 5'd0;
                        end
                    end
                    CMD: begin
                        if (sck_rise) begin
                            cmd_sr <= opcode_next;
                            if (bit_cnt == 5'd7) begin
                                bit_cnt <= 5'd0;
                                fast_q  <= is_fast;
                                if (!opcode_ok) bad_cmd <= 1'b1;
                            end else begin
                                bit_cnt <= bit_cnt + 5'd1;
                            end
                        end
                    end
                    ADDR: begin
                        if (sck_rise) begin
                            addr_sr <= addr_next;
                            if (bit_cnt == 5'd23) begin
                                bit_cnt   <= 5'd0;
                                mem_addr  <= addr_next[ADDR_WIDTH-1:0];
                                mem_rstrb <= 1'b1;
                            end else begin
                                bit_cnt <= bit_cnt + 5'd1;
                            end
                        end
                    end
                    DUMMY: begin
                        if (sck_rise) begin
                            if (bit_cnt == 5'd7) bit_cnt <= 5'd0;
                            else                 bit_cnt <= bit_cnt + 5'd1;
                        end
                    end
                    DATA: begin
                        if (sck_fall) begin
                            if (bit_cnt[2:0] == 3'd0) begin
                                shifter     <= prefetch;
                                spi_miso    <= prefetch[7];
                                spi_miso_oe <= 1'b1;
                                mem_addr    <= mem_addr + ADDR_WIDTH'(1);
                                mem_rstrb   <= 1'b1;
                            end else begin
                                shifter  <= {shifter[6:0], 1'b0};
                                spi_miso <= shifter[6];
                            end
                            bit_cnt <= {2'b00, bit_cnt[2:0] + 3'd1};
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_spi_flash_responder.sv
// tb_spi_flash_responder: directed test of spi_flash_responder acting as an
// SPI mode-0 master at SCK = clk/8 against a registered byte store model.
module tb_spi_flash_responder;

    logic        clk;
    logic        reset;
    logic        spi_clk;
    logic        spi_cs_n;
    logic        spi_mosi;
    logic        spi_miso;
    logic        spi_miso_oe;
    logic [23:0] mem_addr;
    logic        mem_rstrb;
    logic [7:0]  mem_rdata;
    logic        active;
    logic        bad_cmd;

    int vectorCount = 0;
    int failCount   = 0;
    int badCycles   = 0;
    int oeCycles    = 0;
    int rstrbCycles = 0;

    logic [7:0] rxBytes [0:3];

    spi_flash_responder #(.ADDR_WIDTH(24), .READ_CMD(8'h03)) dut (
        .clk         (clk),
        .reset       (reset),
        .spi_clk     (spi_clk),
        .spi_cs_n    (spi_cs_n),
        .spi_mosi    (spi_mosi),
        .spi_miso    (spi_miso),
        .spi_miso_oe (spi_miso_oe),
        .mem_addr    (mem_addr),
        .mem_rstrb   (mem_rstrb),
        .mem_rdata   (mem_rdata),
        .active      (active),
        .bad_cmd     (bad_cmd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Contents of the backing store as the test plan defines it.
    function automatic logic [7:0] memByte(input logic [23:0] a);
        if (a < 24'd16)         return 8'h10 + a[7:0];
        else if (a == 24'hFFFFFE) return 8'hAA;
        else if (a == 24'hFFFFFF) return 8'hBB;
        else                    return a[7:0] ^ 8'h5A;
    endfunction

    // Registered store: data valid one clock after the strobe.
    always @(posedge clk) begin
        if (mem_rstrb) mem_rdata <= memByte(mem_addr);
    end

    // Running counts of cycles each observed output is high.
    always @(posedge clk) begin
        if (bad_cmd)     badCycles   <= badCycles + 1;
        if (spi_miso_oe) oeCycles    <= oeCycles + 1;
        if (mem_rstrb)   rstrbCycles <= rstrbCycles + 1;
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        vectorCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
        end
    endtask

    task automatic halfSck;
        repeat (4) @(negedge clk);
    endtask

    task automatic xferByte(input logic [7:0] tx, output logic [7:0] rx);
        logic [7:0] r;
        r = 8'h00;
        for (int i = 7; i >= 0; i--) begin
            spi_mosi = tx[i];
            halfSck();
            spi_clk = 1'b1;
            r = {r[6:0], spi_miso};
            halfSck();
            spi_clk = 1'b0;
        end
        rx = r;
    endtask

    task automatic startCs;
        spi_cs_n = 1'b0;
        repeat (8) @(negedge clk);
    endtask

    task automatic endCs;
        halfSck();
        spi_cs_n = 1'b1;
        repeat (8) @(negedge clk);
    endtask

    task automatic applyStimulus(input logic [7:0] cmd, input logic [23:0] addr,
                                 input int dummyBytes, input int nBytes);
        logic [7:0] junk;
        startCs();
        xferByte(cmd, junk);
        xferByte(addr[23:16], junk);
        xferByte(addr[15:8], junk);
        xferByte(addr[7:0], junk);
        for (int i = 0; i < dummyBytes; i++) xferByte(8'h00, junk);
        for (int i = 0; i < nBytes; i++) xferByte(8'hFF, rxBytes[i]);
        endCs();
    endtask

    initial begin
        logic [7:0] junk;
        int badStart;
        int oeStart;
        int rstrbStart;

        reset     = 1'b1;
        spi_clk   = 1'b0;
        spi_cs_n  = 1'b1;
        spi_mosi  = 1'b0;
        mem_rdata = 8'h00;
        for (int i = 0; i < 4; i++) rxBytes[i] = 8'h00;
        #1;
        checkOutput("rst_miso",   {31'd0, spi_miso},    32'd0);
        checkOutput("rst_oe",     {31'd0, spi_miso_oe}, 32'd0);
        checkOutput("rst_rstrb",  {31'd0, mem_rstrb},   32'd0);
        checkOutput("rst_addr",   {8'd0, mem_addr},     32'd0);
        checkOutput("rst_active", {31'd0, active},      32'd0);
        checkOutput("rst_badcmd", {31'd0, bad_cmd},     32'd0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (4) @(negedge clk);

        // Plain READ at 0x000004, four bytes.
        applyStimulus(8'h03, 24'h000004, 0, 4);
        checkOutput("rd4_b0", {24'd0, rxBytes[0]}, 32'h14);
        checkOutput("rd4_b1", {24'd0, rxBytes[1]}, 32'h15);
        checkOutput("rd4_b2", {24'd0, rxBytes[2]}, 32'h16);
        checkOutput("rd4_b3", {24'd0, rxBytes[3]}, 32'h17);
        checkOutput("rd4_word", {rxBytes[3], rxBytes[2], rxBytes[1], rxBytes[0]},
                    32'h17161514);
        checkOutput("idle_active", {31'd0, active}, 32'd0);

        // Address wraps from the top of the space back to zero.
        applyStimulus(8'h03, 24'hFFFFFE, 0, 4);
        checkOutput("wrap_b0", {24'd0, rxBytes[0]}, 32'hAA);
        checkOutput("wrap_b1", {24'd0, rxBytes[1]}, 32'hBB);
        checkOutput("wrap_b2", {24'd0, rxBytes[2]}, 32'h10);
        checkOutput("wrap_b3", {24'd0, rxBytes[3]}, 32'h11);

        // Unsupported opcode: single bad_cmd pulse, no response at all.
        badStart   = badCycles;
        oeStart    = oeCycles;
        rstrbStart = rstrbCycles;
        startCs();
        xferByte(8'h9F, junk);
        repeat (4) @(negedge clk);
        checkOutput("bad_pulse", badCycles - badStart, 32'd1);
        xferByte(8'h00, junk);
        xferByte(8'h00, junk);
        xferByte(8'hFF, junk);
        checkOutput("bad_oe", oeCycles - oeStart, 32'd0);
        checkOutput("bad_rstrb", rstrbCycles - rstrbStart, 32'd0);
        checkOutput("bad_pulse_once", badCycles - badStart, 32'd1);
        endCs();
        applyStimulus(8'h03, 24'h000000, 0, 1);
        checkOutput("after_bad_b0", {24'd0, rxBytes[0]}, 32'h10);

        // CS raised part-way through the second data byte.
        startCs();
        xferByte(8'h03, junk);
        xferByte(8'h00, junk);
        xferByte(8'h00, junk);
        xferByte(8'h04, junk);
        xferByte(8'hFF, junk);
        checkOutput("trunc_b0", {24'd0, junk}, 32'h14);
        for (int i = 0; i < 3; i++) begin
            halfSck();
            spi_clk = 1'b1;
            halfSck();
            spi_clk = 1'b0;
        end
        checkOutput("trunc_active_on", {31'd0, active}, 32'd1);
        checkOutput("trunc_oe_on", {31'd0, spi_miso_oe}, 32'd1);
        halfSck();
        rstrbStart = rstrbCycles;
        spi_cs_n = 1'b1;
        repeat (4) @(negedge clk);
        checkOutput("trunc_oe_off", {31'd0, spi_miso_oe}, 32'd0);
        checkOutput("trunc_active_off", {31'd0, active}, 32'd0);
        repeat (20) @(negedge clk);
        checkOutput("trunc_no_rstrb", rstrbCycles - rstrbStart, 32'd0);
        applyStimulus(8'h03, 24'h000008, 0, 1);
        checkOutput("after_trunc_b0", {24'd0, rxBytes[0]}, 32'h18);

        // Asynchronous reset in the middle of the address phase.
        startCs();
        xferByte(8'h03, junk);
        xferByte(8'h00, junk);
        reset = 1'b1;
        #1;
        checkOutput("mid_rst_active", {31'd0, active},      32'd0);
        checkOutput("mid_rst_oe",     {31'd0, spi_miso_oe}, 32'd0);
        checkOutput("mid_rst_addr",   {8'd0, mem_addr},     32'd0);
        checkOutput("mid_rst_rstrb",  {31'd0, mem_rstrb},   32'd0);
        checkOutput("mid_rst_miso",   {31'd0, spi_miso},    32'd0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        oeStart    = oeCycles;
        rstrbStart = rstrbCycles;
        xferByte(8'h03, junk);
        xferByte(8'h00, junk);
        xferByte(8'h00, junk);
        xferByte(8'h00, junk);
        xferByte(8'hFF, junk);
        checkOutput("post_rst_oe", oeCycles - oeStart, 32'd0);
        checkOutput("post_rst_rstrb", rstrbCycles - rstrbStart, 32'd0);
        checkOutput("post_rst_active", {31'd0, active}, 32'd0);
        endCs();
        applyStimulus(8'h03, 24'h000001, 0, 1);
        checkOutput("post_rst_read", {24'd0, rxBytes[0]}, 32'h11);

        // FAST_READ with 8 dummy clocks; rejected when the feature is absent.
        badStart = badCycles;
        oeStart  = oeCycles;
        applyStimulus(8'h0B, 24'h000002, 1, 2);
`ifdef FAST_READ_EN
        checkOutput("fast_b0", {24'd0, rxBytes[0]}, 32'h12);
        checkOutput("fast_b1", {24'd0, rxBytes[1]}, 32'h13);
        checkOutput("fast_no_bad", badCycles - badStart, 32'd0);
`else
        checkOutput("fast_bad_pulse", badCycles - badStart, 32'd1);
        checkOutput("fast_no_oe", oeCycles - oeStart, 32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, failCount);
        $finish;
    end

endmodule
